mem_stage_sram_ctrl: RTL and testbench
======================================

# mem_stage_sram_ctrl

- Memory-stage controller that consumes the EXE/MEM pipeline-register outputs.
- Performs 32-bit loads and stores against an external 16-bit-wide SRAM as two half-word accesses with programmable wait states.
- Stalls the pipeline with `freeze` while an access is in flight, then drives the MEM/WB-facing outputs.
- Sits between the EXE/MEM register and the write-back stage.

## Interface
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: cycles per half-word access; legal range 2..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- WB_en_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control bits from the EXE/MEM register.
- ALU_result_in  in  32  byte address for memory ops, or the result for non-memory ops.
- ST_val_in  in  32  store data.
- Dest_in  in  4  destination register.
- freeze  out  1  pipeline stall; upstream holds all inputs stable while high.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data.
- sram_dq_oe  out  1  write-data drive enable.
- sram_dq_in  in  16  read data.
- sram_we_n  out  1  write strobe, active-low.
- WB_en, MEM_R_EN  out  1 each  registered to write-back.
- ALU_result, MEM_result  out  32 each  registered to write-back.
- Dest  out  4  registered to write-back.

## Operation
- States: IDLE, LO, HI, DONE. A 4-bit wait counter `cnt` runs within LO and HI.
- req = MEM_R_EN_in | MEM_W_EN_in.
- IDLE, req=0 (non-memory instruction):
  - freeze=0.
  - On the edge, WB_en, MEM_R_EN, ALU_result and Dest latch their inputs; MEM_result holds.
- IDLE, req=1:
  - freeze=1.
  - Latch the word address wa = ((ALU_result_in − BASE_ADDR) >> 2).
  - Latch the op type: write if MEM_W_EN_in=1, otherwise read. Write has priority when both are set.
  - Go to LO with cnt=0.
- LO:
  - sram_addr = {wa, 1'b0} truncated to SRAM_AW. Address arithmetic wraps modulo 2^SRAM_AW; address bits [1:0] are ignored.
  - Write: sram_dq_out = ST_val_in[15:0] and sram_dq_oe=1. sram_we_n=0 except on the last cycle of the phase (cnt=WAIT_CYCLES−1).
  - Read: sram_dq_oe=0, sram_we_n=1. sram_dq_in is captured into the low half-word at the edge ending cnt=WAIT_CYCLES−1.
  - Go to HI after WAIT_CYCLES cycles.
- HI:
  - Same as LO with sram_addr = {wa, 1'b1}, using ST_val_in[31:16] and the high half-word.
  - Go to DONE.
- DONE:
  - freeze=0.
  - On the edge, WB_en, MEM_R_EN, ALU_result and Dest latch their inputs.
  - MEM_result is loaded with the assembled word for a read and holds for a write.
  - Go to IDLE. Upstream advances on this same edge, so the next instruction is first seen in IDLE.
- freeze = (IDLE & req) | LO | HI.
- Outside LO and HI: sram_we_n=1, sram_dq_oe=0, sram_addr and sram_dq_out hold their last values.

## Timing
- Reset (rst_n=0 at an edge):
  - State goes to IDLE and cnt to 0.
  - WB_en, MEM_R_EN, ALU_result, MEM_result, Dest, sram_addr and sram_dq_out all reset to 0.
  - sram_we_n=1, sram_dq_oe=0.
  - freeze reads 0 while rst_n is low.
- Reset mid-access aborts the access immediately. No write-back occurs and the SRAM write strobe releases on the next edge.
- Non-memory instruction: one cycle, no stall.
- Memory instruction: freeze is high for 1 + 2·WAIT_CYCLES cycles, then DONE. Total occupancy is 2·WAIT_CYCLES + 2 cycles, which is 6 cycles at default.
- Back-to-back memory ops: each begins in the IDLE cycle after the previous DONE, with no extra bubble.

## Configuration
- MEM_STALL_CNT_EN defined:
  - Adds output `mem_stall_cnt` (32 bits).
  - It increments on every cycle with freeze=1 and saturates at 0xFFFFFFFF.
  - rst_n resets it to 0.
- MEM_STALL_CNT_EN undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Non-memory op, ALU_result_in=0x55, Dest_in=3, WB_en_in=1 -> freeze stays 0; next edge gives ALU_result=0x55, Dest=3, WB_en=1.
- Store of ST_val_in=0xDEADBEEF to address 1032 with WAIT_CYCLES=2:
  - sram_addr=4 for 2 cycles with data 0xBEEF, then sram_addr=5 with 0xDEAD.
  - sram_we_n is low on exactly 1 cycle per phase.
  - freeze is high for 5 cycles.
- Load from 1032 with the SRAM model returning 0xBEEF/0xDEAD -> MEM_result=0xDEADBEEF after DONE and MEM_R_EN=1.
- Both MEM_R_EN_in and MEM_W_EN_in set -> a write is performed and MEM_result is unchanged.
- rst_n driven low during HI of a store:
  - Next edge gives sram_we_n=1, freeze=0, all outputs 0.
  - A subsequent load completes normally.
- Address 1024 + 4·2^(SRAM_AW−1) -> sram_addr wraps to 0 then 1.
- With MEM_STALL_CNT_EN, two back-to-back loads -> mem_stall_cnt=10.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
`default_nettype none
// mem_stage_sram_ctrl_if: EXE/MEM inputs, external SRAM pins and MEM/WB outputs of the memory stage. Rev 1.0
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_AW = 18
);
  logic               WB_en_in;
  logic               MEM_R_EN_in;
  logic               MEM_W_EN_in;
  logic [31:0]        ALU_result_in;
  logic [31:0]        ST_val_in;
  logic [3:0]         Dest_in;
  logic               freeze;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;
  logic               WB_en;
  logic               MEM_R_EN;
  logic [31:0]        ALU_result;
  logic [31:0]        MEM_result;
  logic [3:0]         Dest;

  modport master (
    output WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in, sram_dq_in,
    input  freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    input  WB_en, MEM_R_EN, ALU_result, MEM_result, Dest
  );

  modport slave (
    input  WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in, sram_dq_in,
    output freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    output WB_en, MEM_R_EN, ALU_result, MEM_result, Dest
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// mem_stage_sram_ctrl: MEM stage doing 32-bit loads/stores as two 16-bit SRAM accesses, stalling via freeze. Rev 1.0
// Define MEM_STALL_CNT_EN to add the saturating freeze-cycle counter output mem_stall_cnt.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MEM_STALL_CNT_EN
  output logic [31:0]          mem_stall_cnt,
`endif
  mem_stage_sram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] BASE_VEC = 32'(BASE_ADDR);
  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-2:0] wa_q, wa_d;
  logic               wr_q, wr_d;
  logic [15:0]        lo_q, lo_d, hi_q, hi_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_q, dq_d;
  logic               wb_en_q, wb_en_d;
  logic               mem_r_en_q, mem_r_en_d;
  logic [31:0]        alu_q, alu_d;
  logic [31:0]        mem_res_q, mem_res_d;
  logic [3:0]         dest_q, dest_d;

  logic               req;
  logic               hi_phase;
  logic               last_c;
  logic               freeze_c;
  logic               freeze_o;
  logic               we_n_c;
  logic               oe_c;
  logic               capture_wb;
  logic [SRAM_AW-2:0] wa_calc;

  assign req      = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
  assign hi_phase = (state_q == HI);
  assign last_c   = (cnt_q == LAST_CNT);
  // Word offset computed directly in SRAM width, so it wraps modulo the SRAM size.
  assign wa_calc  = bus.ALU_result_in[SRAM_AW:2] - BASE_VEC[SRAM_AW:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wa_d       = wa_q;
    wr_d       = wr_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    dq_d       = dq_q;
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    alu_d      = alu_q;
    mem_res_d  = mem_res_q;
    dest_d     = dest_q;
    freeze_c   = 1'b0;
    we_n_c     = 1'b1;
    oe_c       = 1'b0;
    capture_wb = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          freeze_c = 1'b1;
          wa_d     = wa_calc;
          wr_d     = bus.MEM_W_EN_in;
          cnt_d    = 4'd0;
          state_d  = LO;
        end else begin
          capture_wb = 1'b1;
        end
      end
      LO, HI: begin
        freeze_c = 1'b1;
        addr_d   = {wa_q, hi_phase};
        if (wr_q) begin
          dq_d = hi_phase ? bus.ST_val_in[31:16] : bus.ST_val_in[15:0];
        end
        oe_c   = wr_q;
        // Strobe released on the final wait cycle so address/data stay valid past the rising edge.
        we_n_c = ~wr_q | last_c;
        if (last_c) begin
          cnt_d   = 4'd0;
          state_d = hi_phase ? DONE : HI;
          if (!wr_q) begin
            if (hi_phase) begin
              hi_d = bus.sram_dq_in;
            end else begin
              lo_d = bus.sram_dq_in;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        capture_wb = 1'b1;
        if (!wr_q) begin
          mem_res_d = {hi_q, lo_q};
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture_wb) begin
      wb_en_d    = bus.WB_en_in;
      mem_r_en_d = bus.MEM_R_EN_in;
      alu_d      = bus.ALU_result_in;
      dest_d     = bus.Dest_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wa_q       <= '0;
      wr_q       <= 1'b0;
      lo_q       <= 16'd0;
      hi_q       <= 16'd0;
      addr_q     <= '0;
      dq_q       <= 16'd0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_q      <= 32'd0;
      mem_res_q  <= 32'd0;
      dest_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wa_q       <= wa_d;
      wr_q       <= wr_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      dq_q       <= dq_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      alu_q      <= alu_d;
      mem_res_q  <= mem_res_d;
      dest_q     <= dest_d;
    end
  end

  assign freeze_o        = rst_n & freeze_c;
  assign bus.freeze      = freeze_o;
  assign bus.sram_addr   = addr_d;
  assign bus.sram_dq_out = dq_d;
  assign bus.sram_dq_oe  = oe_c;
  assign bus.sram_we_n   = we_n_c;
  assign bus.WB_en       = wb_en_q;
  assign bus.MEM_R_EN    = mem_r_en_q;
  assign bus.ALU_result  = alu_q;
  assign bus.MEM_result  = mem_res_q;
  assign bus.Dest        = dest_q;

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else if (freeze_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign mem_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// tb_mem_stage_sram_ctrl: table vectors, reset-abort sequence and random ops checked against a word-level model.
module tb_mem_stage_sram_ctrl;
  localparam int BASE_ADDR   = 1024;
  localparam int SRAM_AW     = 18;
  localparam int WAIT_CYCLES = 2;
  localparam int MEM_FRZ     = 1 + 2 * WAIT_CYCLES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if #(.SRAM_AW(SRAM_AW)) bus ();
`ifdef MEM_STALL_CNT_EN
  logic [31:0] mem_stall_cnt;
`endif

  mem_stage_sram_ctrl #(
    .BASE_ADDR  (BASE_ADDR),
    .SRAM_AW    (SRAM_AW),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef MEM_STALL_CNT_EN
    .mem_stall_cnt(mem_stall_cnt),
`endif
    .bus          (bus)
  );

  // External SRAM: asynchronous read, write on any clock edge with the strobe low.
  logic [15:0] sram_mem [0:(1<<SRAM_AW)-1];
  assign bus.sram_dq_in = sram_mem[bus.sram_addr];
  always @(posedge clk) begin
    if (bus.sram_we_n === 1'b0) sram_mem[bus.sram_addr] = bus.sram_dq_out;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ref_stall;
  logic [31:0] ref_res;
  logic [15:0] ref_mem [int];

  typedef struct {
    logic               w;
    logic               r;
    logic               wb;
    logic [31:0]        addr;
    logic [31:0]        st;
    logic [3:0]         dest;
    int                 exp_frz;
    logic [SRAM_AW-1:0] exp_lo;
    logic [31:0]        exp_res;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [SRAM_AW-1:0] half_addr(input logic [31:0] a);
    logic [31:0] t;
    t = ((a - 32'(BASE_ADDR)) >> 2) << 1;
    return t[SRAM_AW-1:0];
  endfunction

  function automatic logic [15:0] ref_rd(input logic [SRAM_AW-1:0] ha);
    return ref_mem.exists(int'(ha)) ? ref_mem[int'(ha)] : 16'h0000;
  endfunction

  task automatic model_op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] st);
    logic [SRAM_AW-1:0] lo, hi;
    lo = half_addr(a);
    hi = lo + 1'b1;
    if (w) begin
      ref_mem[int'(lo)] = st[15:0];
      ref_mem[int'(hi)] = st[31:16];
    end else if (r) begin
      ref_res = {ref_rd(hi), ref_rd(lo)};
    end
    if (w | r) ref_stall += MEM_FRZ;
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns just after the DONE (or IDLE) edge.
  task automatic run_op(input logic w, input logic r, input logic wb, input logic [31:0] a,
                        input logic [31:0] st, input logic [3:0] d, input int exp_frz,
                        input logic [SRAM_AW-1:0] exp_lo, input logic [31:0] exp_res, input string tag);
    int frz, welo, bad, n;
    logic [SRAM_AW-1:0] exp_a;
    logic in_hi;
    bus.WB_en_in      = wb;
    bus.MEM_R_EN_in   = r;
    bus.MEM_W_EN_in   = w;
    bus.ALU_result_in = a;
    bus.ST_val_in     = st;
    bus.Dest_in       = d;
    #1;
    frz = 0; welo = 0; bad = 0; n = 0;
    while (bus.freeze === 1'b1 && n < 200) begin
      if (bus.sram_we_n !== 1'b1) welo++;
      if (frz > 0) begin
        in_hi = ((frz - 1) >= WAIT_CYCLES);
        exp_a = in_hi ? exp_lo + 1'b1 : exp_lo;
        if (bus.sram_addr !== exp_a) bad++;
        if (bus.sram_dq_oe !== w) bad++;
        if (w && bus.sram_dq_out !== (in_hi ? st[31:16] : st[15:0])) bad++;
        if (((frz - 1) % WAIT_CYCLES) == WAIT_CYCLES - 1 && bus.sram_we_n !== 1'b1) bad++;
      end
      frz++;
      n++;
      @(posedge clk);
      #2;
    end
    if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) bad++;
    check({tag, ".freeze_cycles"}, frz, exp_frz);
    if (w | r) begin
      check({tag, ".sram_phase_errs"}, bad, 0);
      check({tag, ".we_low_cycles"}, welo, w ? 2 * (WAIT_CYCLES - 1) : 0);
    end
    @(posedge clk);
    #1;
    check({tag, ".wb_en_mre_dest"}, {bus.WB_en, bus.MEM_R_EN, bus.Dest}, {wb, r, d});
    check({tag, ".alu_result"}, bus.ALU_result, a);
    check({tag, ".mem_result"}, bus.MEM_result, exp_res);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'h0,         4'd3,  0, 18'd0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'd1032,      32'hDEADBEEF, 4'd5,  5, 18'd4, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'd1032,      32'h0,         4'd7,  5, 18'd4, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'd1032,      32'h12345678, 4'd2,  5, 18'd4, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'd1035,      32'h0,         4'd1,  5, 18'd4, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'd525312,    32'hCAFEF00D, 4'd4,  5, 18'd0, 32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'd1024,      32'h0,         4'd6,  5, 18'd0, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'd525316,    32'h0,         4'd8,  5, 18'd2, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0BAD0BAD, 4'd15, 0, 18'd0, 32'h0};

    foreach (sram_mem[i]) sram_mem[i] = 16'h0000;
    bus.WB_en_in = 1'b0; bus.MEM_R_EN_in = 1'b0; bus.MEM_W_EN_in = 1'b0;
    bus.ALU_result_in = 32'h0; bus.ST_val_in = 32'h0; bus.Dest_in = 4'd0;
    ref_res = 32'h0;
    ref_stall = 0;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.ctrl", {bus.freeze, bus.sram_we_n, bus.sram_dq_oe, bus.WB_en, bus.MEM_R_EN}, 5'b01000);
    check("rst.alu_result", bus.ALU_result, 32'h0);
    check("rst.mem_result", bus.MEM_result, 32'h0);
    check("rst.dest_addr", {bus.Dest, bus.sram_addr}, 32'h0);
    check("rst.dq_out", bus.sram_dq_out, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      model_op(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].st);
      run_op(vecs[i].w, vecs[i].r, vecs[i].wb, vecs[i].addr, vecs[i].st, vecs[i].dest,
             vecs[i].exp_frz, vecs[i].exp_lo, vecs[i].exp_res, $sformatf("vec%0d", i));
    end
`ifdef MEM_STALL_CNT_EN
    check("stall_cnt.table", mem_stall_cnt, ref_stall);
`endif

    // Store to 1040 aborted by reset during the first HI cycle; both halves were already strobed.
    bus.WB_en_in = 1'b1; bus.MEM_R_EN_in = 1'b0; bus.MEM_W_EN_in = 1'b1;
    bus.ALU_result_in = 32'd1040; bus.ST_val_in = 32'h11112222; bus.Dest_in = 4'd9;
    repeat (1 + WAIT_CYCLES) @(posedge clk);
    #1;
    check("abort.in_hi", {bus.freeze, bus.sram_we_n, bus.sram_addr}, {1'b1, 1'b0, 18'd9});
    rst_n = 1'b0;
    #1;
    check("abort.freeze_in_rst", bus.freeze, 1'b0);
    @(posedge clk);
    #1;
    check("abort.ctrl", {bus.freeze, bus.sram_we_n, bus.sram_dq_oe, bus.WB_en, bus.MEM_R_EN}, 5'b01000);
    check("abort.alu_result", bus.ALU_result, 32'h0);
    check("abort.mem_result", bus.MEM_result, 32'h0);
    check("abort.dest_addr", {bus.Dest, bus.sram_addr}, 32'h0);
    check("abort.dq_out", bus.sram_dq_out, 32'h0);
    model_op(1'b1, 1'b0, 32'd1040, 32'h11112222);
    ref_res = 32'h0;
    ref_stall = 0;
    rst_n = 1'b1;

    model_op(1'b0, 1'b1, 32'd1032, 32'h0);
    run_op(1'b0, 1'b1, 1'b1, 32'd1032, 32'h0, 4'd10, MEM_FRZ, half_addr(32'd1032), ref_res, "post_rst_ld0");
    model_op(1'b0, 1'b1, 32'd1040, 32'h0);
    run_op(1'b0, 1'b1, 1'b1, 32'd1040, 32'h0, 4'd11, MEM_FRZ, half_addr(32'd1040), ref_res, "post_rst_ld1");
`ifdef MEM_STALL_CNT_EN
    check("stall_cnt.b2b_loads", mem_stall_cnt, 32'd10);
`endif

    for (int k = 0; k < 60; k++) begin
      logic [1:0]  kind;
      logic [31:0] a, st;
      logic        wb;
      logic [3:0]  d;
      kind = 2'($urandom_range(0, 3));
      st   = $urandom();
      wb   = 1'($urandom_range(0, 1));
      d    = 4'($urandom_range(0, 15));
      if (kind == 2'd0) begin
        a = $urandom();
      end else begin
        a = 32'(BASE_ADDR) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) a = a + 32'(4 << (SRAM_AW - 1));
      end
      model_op(kind[1], kind[0], a, st);
      run_op(kind[1], kind[0], wb, a, st, d, (kind != 2'd0) ? MEM_FRZ : 0,
             half_addr(a), ref_res, $sformatf("rnd%0d", k));
    end
`ifdef MEM_STALL_CNT_EN
    check("stall_cnt.random", mem_stall_cnt, ref_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", n_checks);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
